// File: rtl/io_arbiter.sv
// io_arbiter: two-master, 3-cycle (IDLE/ACCESS/RESP) arbiter onto RAM, keypad, timer and 7-seg register.
// Define IO_ARB_FIXED_PRIO_EN to make m0 win every tie instead of round-robin.
module io_arbiter #(
  parameter logic [15:0] KP_CHK  = 16'h00fc,
  parameter logic [15:0] KP_DAT  = 16'h00fd,
  parameter logic [15:0] SEG_ADR = 16'h00fe,
  parameter logic [15:0] TM_CHK  = 16'h00ff,
  parameter logic [15:0] TM_DAT  = 16'h00fb
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m0_wdata,
  input  logic [15:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [15:0] rdata,
  output logic [7:0]  ram_addr,
  output logic        ram_we,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        kp_sel,
  output logic        tm_sel,
  output logic        kp_ack,
  output logic        tm_ack,
  input  logic [15:0] kp_data,
  input  logic [15:0] tm_data,
  output logic [15:0] seg_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic win, owner, we_q, w_we, periph;
  logic [15:0] addr_q, w_addr, w_wdata, rd_mux;
`ifdef IO_ARB_FIXED_PRIO_EN
  assign win = !m0_req;
`else
  logic last_m1;
  assign win = m1_req && (!m0_req || !last_m1);
`endif
  // gnt is the acceptance strobe of the IDLE cycle; reset masks it while state is forced
  assign m0_gnt = rst_n && state == IDLE && m0_req && !win;
  assign m1_gnt = rst_n && state == IDLE && m1_req && win;
  assign w_we = win ? m1_we : m0_we;
  assign w_addr = win ? m1_addr : m0_addr;
  assign w_wdata = win ? m1_wdata : m0_wdata;
  assign periph = w_addr inside {KP_CHK, KP_DAT, SEG_ADR, TM_CHK, TM_DAT};
  assign rd_mux = (addr_q == KP_CHK || addr_q == KP_DAT) ? kp_data :
                  (addr_q == TM_CHK || addr_q == TM_DAT) ? tm_data :
                  (addr_q == SEG_ADR) ? seg_data : ram_rdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      rdata <= '0;
      ram_addr <= '0;
      ram_we <= 1'b0;
      ram_wdata <= '0;
      kp_sel <= 1'b0;
      tm_sel <= 1'b0;
      kp_ack <= 1'b0;
      tm_ack <= 1'b0;
      seg_data <= '0;
`ifndef IO_ARB_FIXED_PRIO_EN
      last_m1 <= 1'b1;
`endif
    end else if (state == IDLE) begin
      if (m0_req || m1_req) begin
        state <= ACCESS;
        owner <= win;
        we_q <= w_we;
        addr_q <= w_addr;
        ram_wdata <= w_wdata;
        ram_we <= w_we && !periph;
        if (!periph) ram_addr <= w_addr[7:0];
        kp_sel <= !w_we && w_addr == KP_CHK;
        kp_ack <= !w_we && w_addr == KP_DAT;
        tm_sel <= !w_we && w_addr == TM_CHK;
        tm_ack <= !w_we && w_addr == TM_DAT;
`ifndef IO_ARB_FIXED_PRIO_EN
        last_m1 <= win;
`endif
      end
    end else if (state == ACCESS) begin
      state <= RESP;
      ram_we <= 1'b0;
      kp_sel <= 1'b0;
      tm_sel <= 1'b0;
      kp_ack <= 1'b0;
      tm_ack <= 1'b0;
      if (!we_q) rdata <= rd_mux;
      else if (addr_q == SEG_ADR) seg_data <= ram_wdata;
      m0_rvalid <= !we_q && !owner;
      m1_rvalid <= !we_q && owner;
    end else begin
      state <= IDLE;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_io_arbiter.sv
// tb_io_arbiter: directed and random traffic checked against a transaction-level model of io_arbiter.
module tb_io_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic m0_req, m1_req, m0_we, m1_we;
  logic [15:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [15:0] rdata, ram_wdata, ram_rdata, kp_data, tm_data, seg_data;
  logic [7:0] ram_addr;
  logic ram_we, kp_sel, tm_sel, kp_ack, tm_ack;
  logic [15:0] mem [256];
  logic [15:0] mdl_mem [256];
  int n_cmp = 0, n_err = 0;
  int age;
  logic t_who, t_we, last_m1, g0, g1;
  logic [15:0] t_addr, t_wdata, rd_val, rdata_m, seg_m;
  logic [7:0] ra_m;
  int kp_ack_cnt, tm_ack_cnt, ram_we_cnt;
  logic glog[$];

  always #5 clk = ~clk;

  io_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .kp_sel(kp_sel), .tm_sel(tm_sel), .kp_ack(kp_ack),
    .tm_ack(tm_ack), .kp_data(kp_data), .tm_data(tm_data), .seg_data(seg_data)
  );

  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_periph(input logic [15:0] a);
    return a == 16'h00fc || a == 16'h00fd || a == 16'h00fe || a == 16'h00ff || a == 16'h00fb;
  endfunction

  task automatic model_reset();
    age = 0; last_m1 = 1'b1; rdata_m = '0; seg_m = '0; ra_m = '0; g0 = 0; g1 = 0;
  endtask

  // A transaction occupies three consecutive cycles: accept, access, respond
  task automatic check_cycle();
    logic e0, e1, win, we_e, ks, ka, ts, ta, rv0, rv1;
    e0 = 0; e1 = 0; win = 0; we_e = 0; ks = 0; ka = 0; ts = 0; ta = 0; rv0 = 0; rv1 = 0;
    if (age == 0 && (m0_req || m1_req)) begin
`ifdef IO_ARB_FIXED_PRIO_EN
      win = !m0_req;
`else
      win = (m0_req && m1_req) ? !last_m1 : m1_req;
`endif
      e0 = !win; e1 = win;
    end
    if (age == 1) begin
      if (!is_periph(t_addr)) begin
        we_e = t_we; ra_m = t_addr[7:0];
      end
      ks = !t_we && t_addr == 16'h00fc; ka = !t_we && t_addr == 16'h00fd;
      ts = !t_we && t_addr == 16'h00ff; ta = !t_we && t_addr == 16'h00fb;
      rd_val = (t_addr == 16'h00fc || t_addr == 16'h00fd) ? kp_data :
               (t_addr == 16'h00ff || t_addr == 16'h00fb) ? tm_data :
               (t_addr == 16'h00fe) ? seg_m : mdl_mem[t_addr[7:0]];
    end
    if (age == 2) begin
      rv0 = !t_we && !t_who; rv1 = !t_we && t_who;
    end
    if (m0_gnt || m1_gnt) glog.push_back(m1_gnt);
    kp_ack_cnt += int'(kp_ack); tm_ack_cnt += int'(tm_ack); ram_we_cnt += int'(ram_we);
    chk("m0_gnt", m0_gnt, e0);
    chk("m1_gnt", m1_gnt, e1);
    chk("ram_we", ram_we, we_e);
    chk("ram_addr", ram_addr, ra_m);
    if (we_e) chk("ram_wdata", ram_wdata, t_wdata);
    chk("kp_sel", kp_sel, ks);
    chk("kp_ack", kp_ack, ka);
    chk("tm_sel", tm_sel, ts);
    chk("tm_ack", tm_ack, ta);
    chk("m0_rvalid", m0_rvalid, rv0);
    chk("m1_rvalid", m1_rvalid, rv1);
    chk("rdata", rdata, rdata_m);
    chk("seg_data", seg_data, seg_m);
    g0 = e0; g1 = e1;
    if (age == 0 && (e0 || e1)) begin
      t_who = win;
      t_we = win ? m1_we : m0_we;
      t_addr = win ? m1_addr : m0_addr;
      t_wdata = win ? m1_wdata : m0_wdata;
      last_m1 = win;
      age = 1;
    end else if (age == 1) begin
      if (!t_we) rdata_m = rd_val;
      else if (t_addr == 16'h00fe) seg_m = t_wdata;
      if (we_e) mdl_mem[t_addr[7:0]] = t_wdata;
      age = 2;
    end else if (age == 2) age = 0;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input bit who, input bit req, input bit we, input logic [15:0] a, input logic [15:0] d);
    if (who) begin m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; end
    else begin m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; end
  endtask

  task automatic xact(input bit who, input bit we, input logic [15:0] a, input logic [15:0] d);
    set_m(who, 1, we, a, d);
    step();
    set_m(who, 0, we, a, d);
    step();
    step();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_gnt", {m0_gnt, m1_gnt}, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("rst_strobes", {kp_sel, kp_ack, tm_sel, tm_ack, ram_we}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_seg", seg_data, 0);
    chk("rst_ram_addr", ram_addr, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_m(0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0);
    #1;
    chk_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [15:0] rnd_addr();
    int r;
    logic [15:0] a;
    r = $urandom_range(0, 9);
    a = 16'($urandom);
    if (r < 5) a = (r == 0) ? 16'h00fc : (r == 1) ? 16'h00fd : (r == 2) ? 16'h00fe : (r == 3) ? 16'h00ff : 16'h00fb;
    else if (r < 8) a[15:8] = 8'h00;
    return a;
  endfunction

  task automatic rnd_m(input bit who);
    set_m(who, $urandom_range(0, 2) != 0, 1'($urandom), rnd_addr(), 16'($urandom));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      mdl_mem[i] = mem[i];
    end
    kp_data = 16'h0007; tm_data = 16'h5a5a;
    rst_n = 1'b1;
    #2;
    do_reset();
    // single RAM read right after reset
    mem[8'h10] = 16'h1234; mdl_mem[8'h10] = 16'h1234;
    set_m(0, 1, 0, 16'h0010, 0);
    step();
    set_m(0, 0, 0, 16'h0010, 0);
    chk("r40_ram_addr", ram_addr, 8'h10);
    step();
    chk("r40_rvalid", m0_rvalid, 1);
    chk("r40_rdata", rdata, 16'h1234);
    step();
    // ties from a fresh pointer
    do_reset();
    glog.delete();
    set_m(0, 1, 0, 16'h0020, 0);
    set_m(1, 1, 0, 16'h0030, 0);
    for (int i = 0; i < 8; i++) step();
    set_m(0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0);
    step();
    chk("r41_ngrants", glog.size(), 3);
    if (glog.size() >= 3) begin
`ifdef IO_ARB_FIXED_PRIO_EN
      chk("r41_order", {glog[0], glog[1], glog[2]}, 3'b000);
`else
      chk("r41_order", {glog[0], glog[1], glog[2]}, 3'b010);
`endif
    end
    // seven-segment write then read back
    xact(1, 1, 16'h00fe, 16'h00ab);
    chk("r42_seg", seg_data, 16'h00ab);
    xact(0, 0, 16'h00fe, 0);
    chk("r42_rdata", rdata, 16'h00ab);
    // keypad data consume and status
    kp_ack_cnt = 0;
    xact(0, 0, 16'h00fd, 0);
    chk("r43_ack_cycles", kp_ack_cnt, 1);
    chk("r43_rdata", rdata, 16'h0007);
    set_m(0, 1, 0, 16'h00fc, 0);
    step();
    set_m(0, 0, 0, 16'h00fc, 0);
    chk("r43_chk_sel", {kp_sel, kp_ack}, 2'b10);
    step();
    step();
    // aliasing RAM write vs dropped peripheral write
    set_m(0, 1, 1, 16'h01fb, 16'hffff);
    step();
    set_m(0, 0, 1, 16'h01fb, 16'hffff);
    chk("r44_ram", {ram_we, ram_addr}, {1'b1, 8'hfb});
    step();
    step();
    tm_ack_cnt = 0; ram_we_cnt = 0;
    xact(0, 1, 16'h00fb, 16'hffff);
    chk("r44_drop", tm_ack_cnt + ram_we_cnt, 0);
    // random traffic
    for (int c = 0; c < 800; c++) begin
      kp_data = 16'($urandom); tm_data = 16'($urandom);
      if (g0 || !m0_req) rnd_m(0);
      if (g1 || !m1_req) rnd_m(1);
      step();
    end
    set_m(0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step();
    // reset in the middle of a keypad consume
    set_m(0, 1, 0, 16'h00fd, 0);
    step();
    set_m(0, 0, 0, 16'h00fd, 0);
    chk("r45_ack_before", kp_ack, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r45_ack_drop", kp_ack, 0);
    chk("r45_rvalid_drop", {m0_rvalid, m1_rvalid}, 0);
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    kp_ack_cnt = 0;
    for (int i = 0; i < 5; i++) step();
    chk("r45_no_ack", kp_ack_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/io_arbiter.md
IO_ARBITER -- requirements
Module: io_arbiter

Interface
REQ-001 The module SHALL have parameter KP_CHK, default 16'h00fc, meaning the keypad status address.
REQ-002 The module SHALL have parameter KP_DAT, default 16'h00fd, meaning the keypad data address; a read consumes the key.
REQ-003 The module SHALL have parameter SEG_ADR, default 16'h00fe, meaning the seven-segment register address.
REQ-004 The module SHALL have parameter TM_CHK, default 16'h00ff, meaning the timer status address.
REQ-005 The module SHALL have parameter TM_DAT, default 16'h00fb, meaning the timer data address; a read consumes the value.
REQ-006 The module SHALL have the ports: clk  in  1  sole clock, all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 m0_req, m1_req  in  1 each  access request from master 0 (CPU) and master 1 (loader).
REQ-009 m0_we, m1_we  in  1 each  1 = write, 0 = read.
REQ-010 m0_addr, m1_addr  in  16 each  access address.
REQ-011 m0_wdata, m1_wdata  in  16 each  write data.
REQ-012 m0_gnt, m1_gnt  out  1 each  one-cycle pulse: the request has been accepted.
REQ-013 m0_rvalid, m1_rvalid  out  1 each  one-cycle pulse qualifying rdata.
REQ-014 rdata  out  16  read data, shared by both masters.
REQ-015 ram_addr  out  8  RAM address.
REQ-016 ram_we  out  1  RAM write strobe.
REQ-017 ram_wdata  out  16  RAM write data.
REQ-018 ram_rdata  in  16  RAM read data, combinational from ram_addr.
REQ-019 kp_sel, tm_sel  out  1 each  1 = status, 0 = data.
REQ-020 kp_ack, tm_ack  out  1 each  consume pulse to the peripheral.
REQ-021 kp_data, tm_data  in  16 each  peripheral read data.
REQ-022 seg_data  out  16  seven-segment display register.

Function
REQ-023 FSM states SHALL be IDLE, ACCESS and RESP; IDLE->ACCESS on any req, ACCESS->RESP always, RESP->IDLE always, so one transaction takes 3 cycles.
REQ-024 In the IDLE cycle with a request, the FSM SHALL latch the winner's we/addr/wdata and pulse that master's gnt; the master may drop req after gnt.
REQ-025 Arbitration: a lone requester wins; on a tie the master not granted last wins (round-robin); the pointer SHALL reset to "m1 last", so m0 wins the first tie.
REQ-026 In ACCESS, the decode of the latched address SHALL drive the selected target only; all other strobes stay 0.
REQ-027 KP_CHK/TM_CHK reads: sel=1, ack=0.
REQ-028 KP_DAT/TM_DAT reads: sel=0, and ack SHALL be high for exactly one clk during ACCESS.
REQ-029 SEG_ADR write: seg_data SHALL load wdata at the end of ACCESS; a SEG_ADR read returns seg_data.
REQ-030 Any other address: ram_addr=addr[7:0], ram_we=we for ACCESS only (addr[15:8] ignored, wrap-around modulo 256).
REQ-031 Writes to peripheral addresses SHALL be dropped with no ack.
REQ-032 In ACCESS, read data SHALL be registered into rdata; in RESP, the owner's rvalid pulses for reads only.
REQ-033 rdata SHALL hold its value until the next read completes.
REQ-034 Requests arriving in ACCESS/RESP SHALL wait, with no gnt; the worst-case wait under round-robin is 3 cycles.
REQ-035 When sel is idle it SHALL be 0; ram_addr holds its last value.

Reset
REQ-036 On rst_n low, immediately and in any state: FSM=IDLE, all gnt/rvalid/ack/ram_we=0, sel=0, rdata=0, seg_data=0, ram_addr=0, RR pointer=m1.
REQ-037 A transaction in progress at reset SHALL be abandoned, with no rvalid and no write.
REQ-038 The first grant SHALL occur on the first rising edge after rst_n rises with a request present.

Configuration
REQ-039 With macro IO_ARB_FIXED_PRIO_EN defined, m0 SHALL always win ties (the pointer is unused); when undefined, round-robin per REQ-025 applies.

Verification
REQ-040 After reset, m0 reads 0x0010 with RAM=16'h1234: m0_gnt at cycle 1, ram_addr=8'h10 at cycle 2, m0_rvalid with rdata=16'h1234 at cycle 3.
REQ-041 m0 and m1 request together twice back-to-back: grants go m0, m1, m0 (without the macro); with IO_ARB_FIXED_PRIO_EN, m0 gets all three.
REQ-042 m1 writes 16'h00AB to 0x00fe: seg_data=16'h00AB after ACCESS, no rvalid; a read of 0x00fe then returns 16'h00AB.
REQ-043 m0 reads 0x00fd with kp_data=16'h0007: kp_ack is high exactly 1 cycle, kp_sel=0, rdata=7; a read of 0x00fc gives kp_sel=1 and kp_ack=0.
REQ-044 m0 writes 16'hFFFF to 0x01fb and 0x00fb: the first hits ram_addr=8'hfb with ram_we; the second produces no tm_ack and no RAM write.
REQ-045 Assert rst_n low during ACCESS of a KP_DAT read: kp_ack and rvalid drop immediately, and neither pulses again until a new request.
